// File: rtl/rf_wb_arbiter_if.sv
// Writeback/scoreboard bundle between the EXU/LSU/issue stage and rf_wb_arbiter.
// The master modport is the pipeline side, and the slave modport is the arbiter side.
interface rf_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              exu_valid;
  logic              exu_ready;
  logic [ADDR_W-1:0] exu_waddr;
  logic [DATA_W-1:0] exu_wdata;
  logic              lsu_valid;
  logic              lsu_ready;
  logic [ADDR_W-1:0] lsu_waddr;
  logic [DATA_W-1:0] lsu_wdata;
  logic              iss_mark;
  logic [ADDR_W-1:0] iss_rd;
  logic [ADDR_W-1:0] chk_rs1;
  logic [ADDR_W-1:0] chk_rs2;
  logic [ADDR_W-1:0] chk_rd;
  logic              hazard;
  logic              rf_wen;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              sb_err;

  modport master (
    output exu_valid, exu_waddr, exu_wdata,
    output lsu_valid, lsu_waddr, lsu_wdata,
    output iss_mark, iss_rd,
    output chk_rs1, chk_rs2, chk_rd,
    input  exu_ready, lsu_ready, hazard,
    input  rf_wen, rf_waddr, rf_wdata, sb_err
  );

  modport slave (
    input  exu_valid, exu_waddr, exu_wdata,
    input  lsu_valid, lsu_waddr, lsu_wdata,
    input  iss_mark, iss_rd,
    input  chk_rs1, chk_rs2, chk_rd,
    output exu_ready, lsu_ready, hazard,
    output rf_wen, rf_waddr, rf_wdata, sb_err
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin EXU/LSU writeback arbiter onto the register file write port.
// It also keeps the per-register busy scoreboard that the issue stage checks for hazards.
module rf_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic            clk,
  input logic            rst,
  rf_wb_arbiter_if.slave bus
);
  localparam int NREG = 2**ADDR_W;
  localparam logic [NREG-1:0] X0_MASK = {{(NREG-1){1'b1}}, 1'b0};

  logic              r_last_lsu;
  logic              r_wen;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic [NREG-1:0]   r_busy;
  logic              r_err;

  logic              w_exu_rdy;
  logic              w_lsu_rdy;
  logic [NREG-1:0]   w_set;
  logic [NREG-1:0]   w_clr;
  logic              w_err;

  always_comb begin
    w_exu_rdy = !rst && bus.exu_valid &&
                (!bus.lsu_valid || r_last_lsu);
    w_lsu_rdy = !rst && bus.lsu_valid &&
                (!bus.exu_valid || !r_last_lsu);
  end

  // The clear is sourced from the commit flops, so it lands on the same edge as the RF write
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (bus.iss_mark) w_set[bus.iss_rd] = 1'b1;
    if (r_wen)        w_clr[r_waddr]    = 1'b1;
    w_set = w_set & X0_MASK;
    w_err = bus.iss_mark && (bus.iss_rd != '0) &&
            r_busy[bus.iss_rd] && !w_clr[bus.iss_rd];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_lsu <= 1'b1;
      r_wen      <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_busy     <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_exu_rdy) begin
        r_wen      <= (bus.exu_waddr != '0);
        r_waddr    <= bus.exu_waddr;
        r_wdata    <= bus.exu_wdata;
        r_last_lsu <= 1'b0;
      end else if (w_lsu_rdy) begin
        r_wen      <= (bus.lsu_waddr != '0);
        r_waddr    <= bus.lsu_waddr;
        r_wdata    <= bus.lsu_wdata;
        r_last_lsu <= 1'b1;
      end else begin
        r_wen      <= 1'b0;
      end
      r_busy <= ((r_busy & ~w_clr) | w_set) & X0_MASK;
      r_err  <= r_err | w_err;
    end
  end

  assign bus.exu_ready = w_exu_rdy;
  assign bus.lsu_ready = w_lsu_rdy;
  assign bus.rf_wen    = r_wen;
  assign bus.rf_waddr  = r_waddr;
  assign bus.rf_wdata  = r_wdata;
  assign bus.sb_err    = r_err;
  assign bus.hazard    = r_busy[bus.chk_rs1] |
                         r_busy[bus.chk_rs2] |
                         r_busy[bus.chk_rd];
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter.
// It combines an arbitration vector table, a commit scoreboard queue and directed scoreboard sequences.
module tb_rf_wb_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) ifc ();

  rf_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  typedef struct {
    logic        ev;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        xe;
    logic        xl;
  } vec_t;

  typedef struct {
    logic        wen;
    logic [4:0]  a;
    logic [31:0] d;
  } cm_t;

  vec_t        tbl[$];
  cm_t         q[$];
  int          tests = 0;
  int          fails = 0;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  // Checks the readies, lets one edge pass, and then checks the commit port
  task automatic tick(input logic xe, input logic xl);
    cm_t e;
    #2;
    chk("exu_ready", {31'b0, ifc.exu_ready}, {31'b0, xe});
    chk("lsu_ready", {31'b0, ifc.lsu_ready}, {31'b0, xl});
    if (xe)
      q.push_back('{(ifc.exu_waddr != 5'd0),
                    ifc.exu_waddr, ifc.exu_wdata});
    else if (xl)
      q.push_back('{(ifc.lsu_waddr != 5'd0),
                    ifc.lsu_waddr, ifc.lsu_wdata});
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      m_addr = e.a;
      m_data = e.d;
      chk("rf_wen", {31'b0, ifc.rf_wen}, {31'b0, e.wen});
    end else begin
      chk("rf_wen_idle", {31'b0, ifc.rf_wen}, 32'd0);
    end
    chk("rf_waddr", {27'b0, ifc.rf_waddr}, {27'b0, m_addr});
    chk("rf_wdata", ifc.rf_wdata, m_data);
  endtask

  task automatic chk_hz(input string n, input logic exp);
    #1;
    chk(n, {31'b0, ifc.hazard}, {31'b0, exp});
  endtask

  task automatic chk_err(input string n, input logic exp);
    #1;
    chk(n, {31'b0, ifc.sb_err}, {31'b0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    ifc.exu_valid = 1'b1;
    ifc.exu_waddr = 5'd1;
    ifc.exu_wdata = 32'h1;
    ifc.lsu_valid = 1'b1;
    ifc.lsu_waddr = 5'd2;
    ifc.lsu_wdata = 32'h2;
    ifc.iss_mark = 1'b0;
    ifc.iss_rd = '0;
    ifc.chk_rs1 = '0;
    ifc.chk_rs2 = '0;
    ifc.chk_rd = '0;
    m_addr = '0;
    m_data = '0;

    tbl.push_back('{1, 3, 32'hE0, 1, 4, 32'h40, 1, 0});
    tbl.push_back('{1, 3, 32'hE1, 1, 4, 32'h40, 0, 1});
    tbl.push_back('{1, 3, 32'hE1, 1, 4, 32'h41, 1, 0});
    tbl.push_back('{1, 3, 32'hE2, 1, 4, 32'h41, 0, 1});
    tbl.push_back('{0, 0, 32'h0,  0, 0, 32'h0,  0, 0});
    tbl.push_back('{1, 5, 32'h1234, 0, 0, 32'h0, 1, 0});
    tbl.push_back('{0, 0, 32'h0, 1, 0, 32'hDEAD, 0, 1});
    tbl.push_back('{1, 8, 32'h88, 1, 6, 32'h66, 1, 0});
    tbl.push_back('{0, 0, 32'h0, 1, 6, 32'h66, 0, 1});
    tbl.push_back('{0, 0, 32'h0, 0, 0, 32'h0, 0, 0});

    repeat (2) @(posedge clk);
    #1;
    chk("rst_exu_ready", {31'b0, ifc.exu_ready}, 32'd0);
    chk("rst_lsu_ready", {31'b0, ifc.lsu_ready}, 32'd0);
    chk("rst_rf_wen", {31'b0, ifc.rf_wen}, 32'd0);
    chk("rst_rf_waddr", {27'b0, ifc.rf_waddr}, 32'd0);
    chk("rst_rf_wdata", ifc.rf_wdata, 32'd0);
    chk("rst_hazard", {31'b0, ifc.hazard}, 32'd0);
    chk("rst_sb_err", {31'b0, ifc.sb_err}, 32'd0);
    rst = 1'b0;
    ifc.exu_valid = 1'b0;
    ifc.lsu_valid = 1'b0;

    foreach (tbl[i]) begin
      ifc.exu_valid = tbl[i].ev;
      ifc.exu_waddr = tbl[i].ea;
      ifc.exu_wdata = tbl[i].ed;
      ifc.lsu_valid = tbl[i].lv;
      ifc.lsu_waddr = tbl[i].la;
      ifc.lsu_wdata = tbl[i].ld;
      tick(tbl[i].xe, tbl[i].xl);
    end

    // busy is set one edge after the mark and clears on the edge the RF is written
    ifc.iss_mark = 1'b1;
    ifc.iss_rd = 5'd7;
    tick(0, 0);
    ifc.iss_mark = 1'b0;
    ifc.chk_rs1 = 5'd7;
    chk_hz("hz_after_mark7", 1'b1);
    ifc.exu_valid = 1'b1;
    ifc.exu_waddr = 5'd7;
    ifc.exu_wdata = 32'h77;
    tick(1, 0);
    chk_hz("hz_commit_cycle7", 1'b1);
    ifc.exu_valid = 1'b0;
    tick(0, 0);
    chk_hz("hz_cleared7", 1'b0);

    ifc.iss_mark = 1'b1;
    ifc.iss_rd = 5'd0;
    tick(0, 0);
    ifc.iss_mark = 1'b0;
    ifc.chk_rs1 = 5'd0;
    chk_hz("hz_x0", 1'b0);
    chk_err("err_x0", 1'b0);

    // A set and a clear of the same register on one edge leave it busy and raise no error
    ifc.iss_mark = 1'b1;
    ifc.iss_rd = 5'd9;
    tick(0, 0);
    ifc.iss_mark = 1'b0;
    ifc.chk_rd = 5'd9;
    chk_hz("hz_mark9", 1'b1);
    ifc.exu_valid = 1'b1;
    ifc.exu_waddr = 5'd9;
    ifc.exu_wdata = 32'h99;
    tick(1, 0);
    ifc.exu_valid = 1'b0;
    ifc.iss_mark = 1'b1;
    ifc.iss_rd = 5'd9;
    tick(0, 0);
    ifc.iss_mark = 1'b0;
    chk_hz("hz_collision9", 1'b1);
    chk_err("err_collision", 1'b0);
    ifc.iss_mark = 1'b1;
    tick(0, 0);
    ifc.iss_mark = 1'b0;
    chk_err("err_waw", 1'b1);
    tick(0, 0);
    chk_err("err_sticky", 1'b1);

    ifc.iss_mark = 1'b1;
    ifc.iss_rd = 5'd11;
    tick(0, 0);
    ifc.iss_mark = 1'b0;
    ifc.chk_rs1 = 5'd11;
    ifc.exu_valid = 1'b1;
    ifc.exu_waddr = 5'd12;
    ifc.exu_wdata = 32'hC;
    tick(1, 0);
    ifc.lsu_valid = 1'b1;
    ifc.lsu_waddr = 5'd13;
    ifc.lsu_wdata = 32'hD;
    rst = 1'b1;
    #2;
    chk("midrst_exu_ready", {31'b0, ifc.exu_ready}, 32'd0);
    chk("midrst_lsu_ready", {31'b0, ifc.lsu_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_rf_wen", {31'b0, ifc.rf_wen}, 32'd0);
    chk("midrst_rf_waddr", {27'b0, ifc.rf_waddr}, 32'd0);
    chk("midrst_hazard", {31'b0, ifc.hazard}, 32'd0);
    chk("midrst_sb_err", {31'b0, ifc.sb_err}, 32'd0);
    rst = 1'b0;
    m_addr = '0;
    m_data = '0;
    tick(1, 0);
    tick(0, 1);
    ifc.exu_valid = 1'b0;
    ifc.lsu_valid = 1'b0;
    tick(0, 0);
    chk("queue_empty", q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
